// File: rtl/keyboard_matrix_pkg.sv
// Shared constants for the PET keyboard matrix responder: Wishbone window,
// PIA register selects and matrix geometry.
package keyboard_matrix_pkg;

  localparam int          KBD_ROW_COUNT       = 10;
  localparam int          KBD_ADDR_WIDTH      = 4;
  localparam int          WB_ADDR_WIDTH       = 20;
  localparam logic [2:0]  WB_KBD_BASE         = 3'd3;
  localparam int          PIA_CR_DATA_SEL_BIT = 2;
  localparam logic [7:0]  KBD_NO_KEY          = 8'hFF;

  typedef enum logic [1:0] {
    PIA_PORTA = 2'd0,
    PIA_CRA   = 2'd1,
    PIA_PORTB = 2'd2,
    PIA_CRB   = 2'd3
  } pia_rs_e;

  // Wishbone byte address of a keyboard row; bits [16:4] are left at zero.
  function automatic logic [WB_ADDR_WIDTH-1:0] wb_kbd_addr(input logic [KBD_ADDR_WIDTH-1:0] row);
    return {WB_KBD_BASE, 13'd0, row};
  endfunction

endpackage

// File: rtl/keyboard_matrix_wb_reg_target.sv
// Generic Wishbone register responder: window decode, single-cycle ack and
// registered read data. The parent owns the register storage.
module keyboard_matrix_wb_reg_target #(
  parameter int         BASE_WIDTH = 3,
  parameter int         DATA_WIDTH = 8,
  parameter logic [2:0] BASE       = 3'd0
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [BASE_WIDTH-1:0] wb_window_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cycle_i,
  input  logic                  wb_strobe_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic                  wr_en_o
);

  logic                  req;
  logic                  ack_d, ack_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  assign req     = wb_cycle_i & wb_strobe_i & (wb_window_i == BASE);
  assign wr_en_o = req & wb_we_i;

  always_comb begin
    ack_d  = req;
    data_d = data_q;
    // Read data only moves on a read ack so it stays stable between reads.
    if (req && !wb_we_i) begin
      data_d = rd_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_data_o  = data_q;
  assign wb_stall_o = 1'b0;

endmodule

// File: rtl/keyboard_matrix.sv
// PET keyboard matrix: MCU fills rows over Wishbone, the CPU scans them by
// snooping PIA1 row select and reading column data on PORTB.
module keyboard_matrix
  import keyboard_matrix_pkg::*;
#(
  parameter int ROW_COUNT  = KBD_ROW_COUNT,
  parameter int ADDR_WIDTH = KBD_ADDR_WIDTH
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [19:0] wb_addr_i,
  input  logic [7:0]  wb_data_i,
  output logic [7:0]  wb_data_o,
  input  logic        wb_we_i,
  input  logic        wb_cycle_i,
  input  logic        wb_strobe_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  input  logic        pia1_cs_i,
  input  logic [1:0]  pia1_rs_i,
  input  logic        cpu_we_i,
  input  logic        cpu_data_strobe_i,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_oe_o
);

  logic [7:0]            rows_d [ROW_COUNT];
  logic [7:0]            rows_q [ROW_COUNT];
  logic [7:0]            cra_d, cra_q;
  logic [7:0]            crb_d, crb_q;
  logic [ADDR_WIDTH-1:0] row_sel_d, row_sel_q;

  logic [ADDR_WIDTH-1:0] wb_row;
  logic                  wb_wr_en;
  logic [7:0]            wb_rd_data;
  logic [7:0]            cpu_rd_data;
  logic                  cpu_wr;
  logic                  portb_rd;
  logic                  unused_bits;

  assign wb_row      = wb_addr_i[ADDR_WIDTH-1:0];
  assign unused_bits = ^{wb_addr_i[16:ADDR_WIDTH], cra_q, crb_q};

  keyboard_matrix_wb_reg_target #(
    .BASE_WIDTH (3),
    .DATA_WIDTH (8),
    .BASE       (WB_KBD_BASE)
  ) u_wb_target (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .wb_window_i (wb_addr_i[19:17]),
    .wb_we_i     (wb_we_i),
    .wb_cycle_i  (wb_cycle_i),
    .wb_strobe_i (wb_strobe_i),
    .rd_data_i   (wb_rd_data),
    .wb_data_o   (wb_data_o),
    .wb_ack_o    (wb_ack_o),
    .wb_stall_o  (wb_stall_o),
    .wr_en_o     (wb_wr_en)
  );

  // Rows outside the matrix read as "no key pressed".
  always_comb begin
    wb_rd_data  = KBD_NO_KEY;
    cpu_rd_data = KBD_NO_KEY;
    for (int r = 0; r < ROW_COUNT; r++) begin
      if (wb_row == ADDR_WIDTH'(r)) wb_rd_data = rows_q[r];
      if (row_sel_q == ADDR_WIDTH'(r)) cpu_rd_data = rows_q[r];
    end
  end

  generate
    for (genvar gi = 0; gi < ROW_COUNT; gi++) begin : g_row
      always_comb begin
        rows_d[gi] = rows_q[gi];
        if (wb_wr_en && wb_row == ADDR_WIDTH'(gi)) rows_d[gi] = wb_data_i;
      end

      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) rows_q[gi] <= KBD_NO_KEY;
        else            rows_q[gi] <= rows_d[gi];
      end
    end
  endgenerate

  assign cpu_wr = cpu_data_strobe_i & pia1_cs_i & cpu_we_i;

  always_comb begin
    cra_d     = cra_q;
    crb_d     = crb_q;
    row_sel_d = row_sel_q;
    if (cpu_wr) begin
      case (pia1_rs_i)
        PIA_CRA: cra_d = cpu_data_i;
        PIA_CRB: crb_d = cpu_data_i;
        // With the data-select bit clear the CPU is writing DDRA, not the row.
        PIA_PORTA: if (cra_q[PIA_CR_DATA_SEL_BIT]) row_sel_d = cpu_data_i[ADDR_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cra_q     <= '0;
      crb_q     <= '0;
      row_sel_q <= '0;
    end else begin
      cra_q     <= cra_d;
      crb_q     <= crb_d;
      row_sel_q <= row_sel_d;
    end
  end

  assign portb_rd      = pia1_cs_i & ~cpu_we_i & (pia1_rs_i == PIA_PORTB) & crb_q[PIA_CR_DATA_SEL_BIT];
  assign cpu_data_oe_o = portb_rd;
  assign cpu_data_o    = portb_rd ? cpu_rd_data : KBD_NO_KEY;

endmodule

// File: tb/tb_keyboard_matrix.sv
// Self-checking bench for keyboard_matrix: vector table, corner sequences and
// randomized traffic against a simple array model of the key matrix.
module tb_keyboard_matrix;
  import keyboard_matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] wb_addr;
  logic [7:0]  wb_wdata, wb_rdata;
  logic        wb_we, wb_cyc, wb_stb, wb_stall, wb_ack;
  logic        pia_cs;
  logic [1:0]  pia_rs;
  logic        cpu_we, cpu_stb;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_oe;

  always #5 clk = ~clk;

  keyboard_matrix dut (
    .clock_i           (clk),
    .reset_n_i         (rst_n),
    .wb_addr_i         (wb_addr),
    .wb_data_i         (wb_wdata),
    .wb_data_o         (wb_rdata),
    .wb_we_i           (wb_we),
    .wb_cycle_i        (wb_cyc),
    .wb_strobe_i       (wb_stb),
    .wb_stall_o        (wb_stall),
    .wb_ack_o          (wb_ack),
    .pia1_cs_i         (pia_cs),
    .pia1_rs_i         (pia_rs),
    .cpu_we_i          (cpu_we),
    .cpu_data_strobe_i (cpu_stb),
    .cpu_data_i        (cpu_din),
    .cpu_data_o        (cpu_dout),
    .cpu_data_oe_o     (cpu_oe)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: the matrix as an array plus the three CPU-visible registers.
  logic [7:0] m_rows [KBD_ROW_COUNT];
  logic [7:0] m_cra, m_crb;
  int         m_sel;

  localparam int K_WBW = 0, K_WBR = 1, K_CPUW = 2, K_CPUR = 3;
  typedef struct {
    int         kind;
    logic [3:0] arg;
    logic [7:0] data;
    logic       exp_oe;
    logic [7:0] exp_val;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  function automatic logic [7:0] m_row(input int idx);
    return (idx < KBD_ROW_COUNT) ? m_rows[idx] : 8'hFF;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < KBD_ROW_COUNT; i++) m_rows[i] = 8'hFF;
    m_cra = 8'h00;
    m_crb = 8'h00;
    m_sel = 0;
  endtask

  task automatic idle();
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_wdata = '0;
    pia_cs = 0; pia_rs = 2'd0; cpu_we = 0; cpu_stb = 0; cpu_din = '0;
  endtask

  // Starts just after a rising edge; one request cycle, then one idle cycle.
  task automatic wb_xfer(input logic we, input logic [2:0] base, input logic [3:0] row,
                         input logic [7:0] data, input logic [12:0] junk,
                         output logic ack0, output logic ack1, output logic [7:0] rdata,
                         output logic ack2);
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_wdata = data;
    wb_addr = {base, junk, row};
    #1 ack0 = wb_ack;
    @(posedge clk); #1;
    ack1 = wb_ack; rdata = wb_rdata;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    if (we && base == WB_KBD_BASE && row < KBD_ROW_COUNT) m_rows[row] = data;
    @(posedge clk); #1;
    ack2 = wb_ack;
  endtask

  task automatic cpu_write(input logic [1:0] rs, input logic [7:0] data, input logic stb);
    pia_cs = 1; cpu_we = 1; pia_rs = rs; cpu_din = data; cpu_stb = stb;
    @(posedge clk); #1;
    idle();
    if (stb) begin
      if (rs == 2'd1) m_cra = data;
      if (rs == 2'd3) m_crb = data;
      if (rs == 2'd0 && m_cra[2]) m_sel = int'(data[3:0]);
    end
  endtask

  task automatic cpu_read(input logic [1:0] rs, output logic oe, output logic [7:0] d);
    pia_cs = 1; cpu_we = 0; pia_rs = rs; cpu_stb = 1; cpu_din = 8'h5A;
    #1 oe = cpu_oe; d = cpu_dout;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic push(input int kind, input logic [3:0] arg, input logic [7:0] data,
                      input logic exp_oe, input logic [7:0] exp_val);
    vec_t v;
    v.kind = kind; v.arg = arg; v.data = data; v.exp_oe = exp_oe; v.exp_val = exp_val;
    tbl.push_back(v);
  endtask

  initial begin
    logic       a0, a1, a2, oe;
    logic [7:0] rd;

    for (int r = 0; r < KBD_ROW_COUNT; r++) push(K_WBR, 4'(r), 8'h00, 1'b0, 8'hFF);
    push(K_WBW, 4'd3, 8'hFE, 1'b0, 8'h00);
    push(K_CPUW, 4'd1, 8'h04, 1'b0, 8'h00);
    push(K_CPUW, 4'd0, 8'h03, 1'b0, 8'h00);
    push(K_CPUW, 4'd3, 8'h04, 1'b0, 8'h00);
    push(K_CPUR, 4'd2, 8'h00, 1'b1, 8'hFE);
    push(K_CPUR, 4'd0, 8'h00, 1'b0, 8'h00);
    push(K_WBW, 4'd12, 8'h00, 1'b0, 8'h00);
    push(K_WBR, 4'd12, 8'h00, 1'b0, 8'hFF);
    push(K_WBR, 4'd3, 8'h00, 1'b0, 8'hFE);
    push(K_CPUW, 4'd0, 8'h0C, 1'b0, 8'h00);
    push(K_CPUR, 4'd2, 8'h00, 1'b1, 8'hFF);
    push(K_CPUW, 4'd0, 8'h03, 1'b0, 8'h00);
    push(K_CPUR, 4'd2, 8'h00, 1'b1, 8'hFE);
    push(K_CPUW, 4'd1, 8'h00, 1'b0, 8'h00);
    push(K_CPUW, 4'd0, 8'h05, 1'b0, 8'h00);
    push(K_CPUR, 4'd2, 8'h00, 1'b1, 8'hFE);
    push(K_CPUW, 4'd3, 8'h00, 1'b0, 8'h00);
    push(K_CPUR, 4'd2, 8'h00, 1'b0, 8'h00);

    idle();
    m_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack, 0);
    check("rst_wb_data", wb_rdata, 8'h00);
    check("rst_oe", cpu_oe, 0);
    check("rst_cpu_data", cpu_dout, 8'hFF);
    check("rst_stall", wb_stall, 0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_WBW: begin
          wb_xfer(1'b1, WB_KBD_BASE, tbl[i].arg, tbl[i].data, 13'd0, a0, a1, rd, a2);
          check($sformatf("tbl%0d_wr_ack", i), {a0, a1, a2}, 3'b010);
        end
        K_WBR: begin
          wb_xfer(1'b0, WB_KBD_BASE, tbl[i].arg, 8'h00, 13'd0, a0, a1, rd, a2);
          check($sformatf("tbl%0d_rd_ack", i), {a0, a1, a2}, 3'b010);
          check($sformatf("tbl%0d_rd_row%0d", i, tbl[i].arg), rd, tbl[i].exp_val);
        end
        K_CPUW: cpu_write(tbl[i].arg[1:0], tbl[i].data, 1'b1);
        default: begin
          cpu_read(tbl[i].arg[1:0], oe, rd);
          check($sformatf("tbl%0d_oe", i), oe, tbl[i].exp_oe);
          if (tbl[i].exp_oe) check($sformatf("tbl%0d_col", i), rd, tbl[i].exp_val);
        end
      endcase
    end

    // Back-to-back reads, cycle dropped while the second ack is still pending.
    wb_xfer(1'b1, WB_KBD_BASE, 4'd4, 8'hA5, 13'h1ABC, a0, a1, rd, a2);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = wb_kbd_addr(4'd3);
    @(posedge clk); #1;
    check("b2b_ack1", wb_ack, 1);
    check("b2b_data1", wb_rdata, 8'hFE);
    wb_addr = wb_kbd_addr(4'd4);
    @(posedge clk); #1;
    idle();
    check("b2b_ack2", wb_ack, 1);
    check("b2b_data2", wb_rdata, 8'hA5);
    @(posedge clk); #1;
    check("b2b_ack_end", wb_ack, 0);
    check("b2b_data_hold", wb_rdata, 8'hA5);

    // Request outside the window is ignored.
    wb_xfer(1'b1, WB_KBD_BASE ^ 3'd1, 4'd4, 8'h00, 13'd0, a0, a1, rd, a2);
    check("foreign_ack", a1, 0);
    wb_xfer(1'b0, WB_KBD_BASE, 4'd4, 8'h00, 13'd0, a0, a1, rd, a2);
    check("foreign_nowrite", rd, 8'hA5);

    // Same-cycle WB write and CPU scan of that row.
    cpu_write(2'd1, 8'h04, 1'b1);
    cpu_write(2'd0, 8'h02, 1'b1);
    cpu_write(2'd3, 8'h04, 1'b1);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = wb_kbd_addr(4'd2); wb_wdata = 8'h7F;
    pia_cs = 1; cpu_we = 0; pia_rs = 2'd2;
    #1;
    check("same_cyc_oe", cpu_oe, 1);
    check("same_cyc_old", cpu_dout, 8'hFF);
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    #1;
    check("same_cyc_ack", wb_ack, 1);
    check("same_cyc_new", cpu_dout, 8'h7F);
    m_rows[2] = 8'h7F;
    @(posedge clk); #1;
    idle();

    // Reset in the middle of a write request.
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = wb_kbd_addr(4'd5); wb_wdata = 8'h00;
    #1 rst_n = 0;
    #1 check("rst_mid_ack_async", wb_ack, 0);
    @(posedge clk); #1;
    check("rst_mid_ack", wb_ack, 0);
    idle();
    rst_n = 1;
    m_reset();
    @(posedge clk); #1;
    check("rst_mid_ack_after", wb_ack, 0);
    wb_xfer(1'b0, WB_KBD_BASE, 4'd5, 8'h00, 13'd0, a0, a1, rd, a2);
    check("rst_mid_row5", rd, 8'hFF);
    wb_xfer(1'b0, WB_KBD_BASE, 4'd2, 8'h00, 13'd0, a0, a1, rd, a2);
    check("rst_mid_row2", rd, 8'hFF);
    cpu_read(2'd2, oe, rd);
    check("rst_mid_crb_oe", oe, 0);
    wb_xfer(1'b1, WB_KBD_BASE, 4'd0, 8'h00, 13'd0, a0, a1, rd, a2);
    cpu_write(2'd0, 8'h05, 1'b1);
    cpu_write(2'd3, 8'h04, 1'b1);
    cpu_read(2'd2, oe, rd);
    check("rst_mid_sel_oe", oe, 1);
    check("rst_mid_sel0", rd, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int         op;
      logic [3:0] row;
      logic [7:0] d;
      logic [1:0] rs;
      logic       exp_oe;
      op  = $urandom_range(0, 5);
      row = 4'($urandom_range(0, 15));
      d   = 8'($urandom);
      rs  = 2'($urandom_range(0, 3));
      case (op)
        0: begin
          wb_xfer(1'b1, WB_KBD_BASE, row, d, 13'($urandom), a0, a1, rd, a2);
          check($sformatf("rnd%0d_wr_ack", n), {a0, a1, a2}, 3'b010);
        end
        1: begin
          wb_xfer(1'b0, WB_KBD_BASE, row, 8'h00, 13'($urandom), a0, a1, rd, a2);
          check($sformatf("rnd%0d_rd_ack", n), {a0, a1, a2}, 3'b010);
          check($sformatf("rnd%0d_rd_row%0d", n, row), rd, m_row(int'(row)));
        end
        2: cpu_write(rs, d, ($urandom_range(0, 3) != 0));
        5: check($sformatf("rnd%0d_stall", n), wb_stall, 0);
        default: begin
          cpu_read(rs, oe, rd);
          exp_oe = (rs == 2'd2) && m_crb[2];
          check($sformatf("rnd%0d_oe", n), oe, exp_oe);
          if (exp_oe) check($sformatf("rnd%0d_col_sel%0d", n, m_sel), rd, m_row(m_sel));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got stuck expected done");
    $fatal(1, "timeout");
  end

endmodule
